// File: rtl/engine_out_accum.sv
// Output accumulator for the four-engine convolution top: sums NUM_PASS partial-sum beats
// per pixel pair, applies ReLU / shift / 8-bit saturation and queues results in a FWFT FIFO.
module engine_out_accum #(
  parameter int unsigned NUM_PASS   = 4,
  parameter int unsigned SHIFT      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic        in_valid,
  input  logic [15:0] ina,
  input  logic [15:0] inb,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  pass_cnt,
  output logic [4:0]  fifo_count,
  output logic        overflow_flag,
  output logic        busy
);

  localparam int unsigned IN_W  = 16;
  localparam int unsigned ACC_W = 20;
  localparam int unsigned PW    = 4;
  localparam int unsigned CW    = 5;
  localparam int unsigned QW    = 8;
  localparam int unsigned DW    = 2 * QW;
  localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  // ReLU, arithmetic shift, then clamp to the unsigned 8-bit range
  function automatic logic [QW-1:0] requant(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W-1:0] sh;
    logic [QW-1:0]           q;
    sh = s >>> SHIFT;
    if (s[ACC_W-1]) begin
      q = '0;
    end else if (|sh[ACC_W-1:QW]) begin
      q = '1;
    end else begin
      q = sh[QW-1:0];
    end
    return q;
  endfunction

  // Accumulation-side state
  logic signed [ACC_W-1:0] acc_a_q, acc_a_d;
  logic signed [ACC_W-1:0] acc_b_q, acc_b_d;
  logic [PW-1:0]           pass_cnt_q, pass_cnt_d;
  logic [QW-1:0]           quant_a_q, quant_a_d;
  logic [QW-1:0]           quant_b_q, quant_b_d;
  logic                    quant_valid_q, quant_valid_d;

  // FIFO state
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic                    beat_acc_c;
  logic                    first_beat_c;
  logic                    last_beat_c;
  logic signed [ACC_W-1:0] ina_ext_c, inb_ext_c;
  logic signed [ACC_W-1:0] sum_a_c, sum_b_c;
  logic                    push_c, pop_c, full_c, wr_en_c, drop_c;

  assign beat_acc_c   = en && !clr && in_valid;
  assign first_beat_c = (pass_cnt_q == '0);
  assign last_beat_c  = (pass_cnt_q == LAST_PASS);
  assign ina_ext_c    = {{(ACC_W - IN_W){ina[IN_W-1]}}, ina};
  assign inb_ext_c    = {{(ACC_W - IN_W){inb[IN_W-1]}}, inb};
  assign sum_a_c      = (first_beat_c ? 20'sd0 : acc_a_q) + ina_ext_c;
  assign sum_b_c      = (first_beat_c ? 20'sd0 : acc_b_q) + inb_ext_c;

  // Accumulator, pass counter and quant stage next-state; clr wins over a same-cycle beat
  always_comb begin
    acc_a_d       = acc_a_q;
    acc_b_d       = acc_b_q;
    pass_cnt_d    = pass_cnt_q;
    quant_a_d     = quant_a_q;
    quant_b_d     = quant_b_q;
    quant_valid_d = 1'b0;
    if (clr) begin
      acc_a_d    = '0;
      acc_b_d    = '0;
      pass_cnt_d = '0;
      quant_a_d  = '0;
      quant_b_d  = '0;
    end else if (beat_acc_c) begin
      acc_a_d = sum_a_c;
      acc_b_d = sum_b_c;
      if (last_beat_c) begin
        pass_cnt_d    = '0;
        quant_a_d     = requant(sum_a_c);
        quant_b_d     = requant(sum_b_c);
        quant_valid_d = 1'b1;
      end else begin
        pass_cnt_d = pass_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_a_q       <= '0;
      acc_b_q       <= '0;
      pass_cnt_q    <= '0;
      quant_a_q     <= '0;
      quant_b_q     <= '0;
      quant_valid_q <= 1'b0;
    end else begin
      acc_a_q       <= acc_a_d;
      acc_b_q       <= acc_b_d;
      pass_cnt_q    <= pass_cnt_d;
      quant_a_q     <= quant_a_d;
      quant_b_q     <= quant_b_d;
      quant_valid_q <= quant_valid_d;
    end
  end

  // A full FIFO still takes a word when the head leaves in the same cycle
  assign push_c  = quant_valid_q && !clr;
  assign pop_c   = (count_q != '0) && out_ready;
  assign full_c  = (count_q == FULL_CNT);
  assign wr_en_c = push_c && (!full_c || pop_c);
  assign drop_c  = push_c && full_c && !pop_c;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop_c;
    if (wr_en_c) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en_c, pop_c})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
    if (clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array carries no reset; the read side masks it while empty
  always_ff @(posedge clk) begin
    if (rst && wr_en_c) begin
      mem_q[wr_ptr_q] <= {quant_b_q, quant_a_q};
    end
  end

  assign out_valid     = (count_q != '0);
  assign out_data      = out_valid ? mem_q[rd_ptr_q] : '0;
  assign pass_cnt      = pass_cnt_q;
  assign fifo_count    = count_q;
  assign overflow_flag = overflow_q;
  assign busy          = (pass_cnt_q != '0) || quant_valid_q || out_valid;

endmodule

// File: doc/engine_out_accum.md
# engine_out_accum

Downstream stage of the four-engine convolution top. It takes the summed `outa`/`outb` partial-sum pair on every valid beat and accumulates NUM_PASS beats per output pixel pair. Each finished pair goes through ReLU, a right-shift requantisation and saturation to 8 bits, then into a small first-word-fall-through FIFO. The FIFO is drained by a valid/ready consumer such as the writeback or pooling stage.

## Interface
- NUM_PASS, 4: partial-sum beats accumulated per output pair; legal range 1..16.
- SHIFT, 4: arithmetic right shift applied before saturation; legal range 0..11.
- FIFO_DEPTH, 8: output FIFO entries; power of two, 2..16.

- clk  in  1  Single clock; all logic on the rising edge.
- rst  in  1  Synchronous, active-low reset.
- en  in  1  Accumulation-side enable; low freezes the accumulator and pass counter.
- clr  in  1  Synchronous tile restart: zeroes acc, pass_cnt, quant stage and overflow_flag. FIFO contents are kept.
- in_valid  in  1  Beat qualifier for ina/inb, driven from the engine valid flag.
- ina  in  16  Signed two's-complement partial sum A (engine `outa`).
- inb  in  16  Signed partial sum B (engine `outb`).
- out_data  out  16  FIFO head, {qb[7:0], qa[7:0]}.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  Consumer accept.
- pass_cnt  out  4  Beats accumulated for the current pair.
- fifo_count  out  5  Current FIFO occupancy.
- overflow_flag  out  1  Sticky; set when a finished pair is dropped because the FIFO is full.
- busy  out  1  High when pass_cnt≠0, quant_valid or out_valid.

## Operation
- **Beat acceptance:** a beat is accepted when rst=1, en=1, clr=0 and in_valid=1.
- **Accumulators:** acc_a and acc_b are 20-bit signed. Inputs are sign-extended to 20 bits.
  - First beat (pass_cnt=0): acc ← input.
  - Later beats: acc ← acc + input.
  - 16×(±32768) fits in 20 bits, so there is no accumulator overflow handling.
- **Pass counter:** increments per accepted beat and wraps to 0 after the beat where pass_cnt=NUM_PASS−1. That beat is the final beat.
- **Final beat:** sum = acc + input, computed combinationally, then processed per lane:
  - ReLU: negative → 0.
  - Shift: >>> SHIFT.
  - Saturate: values >255 → 255.
  - The result is registered into quant_a/quant_b and quant_valid is set for one cycle.
  - With NUM_PASS=1, every accepted beat is a final beat.
- **FIFO push:** occurs in any cycle where quant_valid=1.
  - Push when full with no simultaneous pop: the word is dropped and overflow_flag is set.
  - Push when full with a simultaneous pop: the word is accepted and occupancy is unchanged.
- **FIFO pop:** out_valid && out_ready. Pops are independent of en and clr.
- **FIFO status:** out_data shows the head entry combinationally from the FIFO array. When the FIFO is empty it is don't-care but must be stable. Read and write pointers wrap modulo FIFO_DEPTH.
- **clr:** has priority over a same-cycle accepted beat (the beat is discarded) and cancels a pending quant_valid.
- **Reset (rst=0, synchronous):** clears acc, pass_cnt, quant stage, FIFO pointers/count and overflow_flag.
  - Reset values: out_valid=0, out_data=0, fifo_count=0, pass_cnt=0, overflow_flag=0, busy=0.
  - Reset mid-pair discards the partial accumulation.

## Timing
- **Latency:** final beat in cycle t → quant_valid in t+1 → FIFO write at the end of t+1 → out_valid=1 in t+2 (FIFO previously empty).
- **Throughput:** one beat per cycle with no bubbles. A finished pair is produced every NUM_PASS accepted beats.
- **Pop timing:** a pop at the end of cycle t updates out_data and fifo_count in t+1.
- **Sticky overflow:** overflow_flag rises the cycle after the dropped push and holds until clr or rst.
- **en low:** in_valid is ignored; acc and pass_cnt hold. A quant_valid already registered still pushes.

## Test plan
- **Basic pair:** NUM_PASS=4, SHIFT=4; ina=100 and inb=16'hFFCE (−50), four consecutive valid beats → out_data=16'h0019 exactly 2 cycles after the 4th beat; pass_cnt sequence 0,1,2,3,0.
- **Saturation:** ina=inb=16'h7FFF for 4 beats → out_data=16'hFFFF. Then ina=16, inb=31 for 4 beats → out_data=16'h0704.
- **Backpressure/overflow:** out_ready=0, produce 9 pairs with FIFO_DEPTH=8 → fifo_count=8, overflow_flag=1 after the 9th push. Raise out_ready → the first 8 words come out in order, then out_valid=0.
- **Full push+pop:** FIFO full, out_ready=1 in the cycle quant_valid=1 → word accepted, fifo_count stays 8, overflow_flag stays 0.
- **en gaps and clr:** drop en for 3 cycles between beats 2 and 3 → same result as the gapless run. Assert clr after beat 2 → pass_cnt=0, no output. The next 4 beats form a fresh pair.
- **Mid-operation reset:** rst=0 for one cycle with 3 FIFO entries and pass_cnt=2 → next cycle out_valid=0, fifo_count=0, pass_cnt=0, overflow_flag=0.
